// File: rtl/wb_daq_pkg.sv
// Shared Wishbone cycle-type codes and the responder FSM encoding for the DAQ sample buffer.
package wb_daq_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StAck,
        StBurst,
        StErr
    } wb_state_e;

endpackage

// File: rtl/wb_daq_sram_mem.sv
// Sample SRAM: one registered read port and one byte-enabled write port.
module wb_daq_sram_mem
    import wb_daq_pkg::*;
#(
    parameter int unsigned mem_words = 1024,
    parameter mem_image = "",
    localparam int unsigned IdxW = $clog2(mem_words)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [IdxW-1:0] wr_addr,
    input  logic [3:0]      be,
    input  logic [31:0]     wdata,
    input  logic [IdxW-1:0] rd_addr,
    output logic [31:0]     rdata
);

    logic [31:0] mem_q [mem_words];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem_q[wr_addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Only the read register is reset so the bus data output starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/wb_daq_sram_responder.sv
// Wishbone B3 slave fronting the DAQ sample SRAM, with a write-beat counter and fill-level irq.
module wb_daq_sram_responder
    import wb_daq_pkg::*;
#(
    parameter int unsigned   dw          = 32,
    parameter int unsigned   aw          = 32,
    parameter int unsigned   mem_words   = 1024,
    parameter logic [aw-1:0] base_addr   = '0,
    parameter int unsigned   wait_states = 0,
    parameter                mem_image   = ""
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [aw-1:0] wb_adr_i,
    input  logic [dw-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [dw-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o,
    input  logic          count_clear,
    input  logic [15:0]   threshold,
    output logic [15:0]   words_written,
    output logic          threshold_irq
);

    localparam int unsigned IdxW   = $clog2(mem_words);
    localparam int unsigned PtrW   = IdxW + 1;
    localparam logic [2:0]  WsLast = 3'(wait_states - 1);

    wb_state_e       state_q, state_d;
    logic [PtrW-1:0] ptr_q, ptr_d, ptr_next;
    logic [2:0]      ws_q, ws_d;
    logic            term_q;
    logic [15:0]     ww_q;
    logic            irq_q;

    logic [aw-1:0]   off;
    logic [IdxW-1:0] idx, wr_idx, rd_idx;
    logic            in_range, req, ack, err, mem_we;
    logic            unused_off;

    assign off        = wb_adr_i - base_addr;
    assign idx        = off[IdxW+1:2];
    assign in_range   = (wb_adr_i >= base_addr) && (off[aw-1:IdxW+2] == '0);
    assign unused_off = ^off[1:0];
    assign req        = wb_cyc_i & wb_stb_i;
    assign ptr_next   = ptr_q + PtrW'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ws_d    = ws_q;
        ack     = 1'b0;
        err     = 1'b0;
        mem_we  = 1'b0;
        wr_idx  = idx;
        rd_idx  = idx;
        unique case (state_q)
            StIdle: begin
                // term_q blocks a held strobe from re-triggering right after termination.
                if (req && !term_q) begin
                    if (!in_range || (wb_cti_i == CTI_INCR && wb_bte_i != BTE_LINEAR)) begin
                        state_d = StErr;
                    end else if (wb_cti_i == CTI_INCR && wait_states == 0) begin
                        state_d = StBurst;
                        ptr_d   = {1'b0, idx};
                    end else if (wait_states == 0) begin
                        state_d = StAck;
                    end else begin
                        state_d = StWait;
                        ws_d    = '0;
                    end
                end
            end
            StWait: begin
                if (ws_q == WsLast) begin
                    state_d = StAck;
                end else begin
                    ws_d = ws_q + 3'd1;
                end
            end
            StAck: begin
                ack     = req;
                mem_we  = req & wb_we_i;
                state_d = StIdle;
            end
            StBurst: begin
                rd_idx = ptr_q[IdxW-1:0];
                if (req) begin
                    if (ptr_q[IdxW]) begin
                        err     = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ack    = 1'b1;
                        mem_we = wb_we_i;
                        wr_idx = ptr_q[IdxW-1:0];
                        ptr_d  = ptr_next;
                        // Prefetch the next word so the following beat can ack at once.
                        rd_idx = ptr_next[IdxW-1:0];
                        if (wb_cti_i == CTI_EOB) begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            StErr: begin
                err     = req;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (!wb_cyc_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            ws_q    <= '0;
            term_q  <= 1'b0;
            ww_q    <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ws_q    <= ws_d;
            term_q  <= ack | err;
            if (count_clear) begin
                ww_q <= '0;
            end else if (ack && wb_we_i && ww_q != 16'hFFFF) begin
                ww_q <= ww_q + 16'd1;
            end
            irq_q <= (threshold != '0) && (ww_q >= threshold);
        end
    end

    wb_daq_sram_mem #(
        .mem_words (mem_words),
        .mem_image (mem_image)
    ) u_mem (
        .clk     (wb_clk),
        .rst     (wb_rst),
        .we      (mem_we),
        .wr_addr (wr_idx),
        .be      (wb_sel_i),
        .wdata   (wb_dat_i),
        .rd_addr (rd_idx),
        .rdata   (wb_dat_o)
    );

    assign wb_ack_o      = ack;
    assign wb_err_o      = err;
    assign wb_rty_o      = 1'b0;
    assign words_written = ww_q;
    assign threshold_irq = irq_q;

endmodule

// File: tb/tb_wb_daq_sram_responder.sv
// Scoreboard bench for the DAQ sample SRAM responder (zero and three wait-state instances).
module tb_wb_daq_sram_responder;
    import wb_daq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr, dat_i, dat_o, dat_o2;
    logic [3:0]  sel;
    logic        we, cyc, stb, cyc2, stb2;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack, err, rty, ack2, err2, rty2;
    logic        count_clear;
    logic [15:0] threshold, ww, ww2;
    logic        irq, irq2;

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_ww   = 0;
    int          exp_ww2  = 0;
    logic [31:0] exp_q [$];
    logic [31:0] model [2][1024];

    always #5 clk = ~clk;

    wb_daq_sram_responder u_dut (
        .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty),
        .count_clear(count_clear), .threshold(threshold), .words_written(ww),
        .threshold_irq(irq)
    );

    wb_daq_sram_responder #(.wait_states(3)) u_dut_ws (
        .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc2), .wb_stb_i(stb2), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(dat_o2), .wb_ack_o(ack2), .wb_err_o(err2), .wb_rty_o(rty2),
        .count_clear(count_clear), .threshold(threshold), .words_written(ww2),
        .threshold_irq(irq2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic classic(input bit inst, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit w, input logic [2:0] c,
                           input logic [1:0] b, input bit exp_ack, input int exp_lat,
                           input string tag);
        bit          got_ack, got_err;
        int          lat;
        logic [31:0] rd;
        @(posedge clk); #1;
        adr = a; dat_i = d; sel = s; we = w; cti = c; bte = b;
        if (inst) begin cyc2 = 1'b1; stb2 = 1'b1; end
        else      begin cyc  = 1'b1; stb  = 1'b1; end
        if (!w && exp_ack) exp_q.push_back(model[inst][a[11:2]]);
        got_ack = 1'b0; got_err = 1'b0; lat = 0; rd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            got_ack = inst ? ack2 : ack;
            got_err = inst ? err2 : err;
            rd      = inst ? dat_o2 : dat_o;
            if (got_ack || got_err) break;
            lat++;
        end
        check_eq({tag, "_ack"}, 32'(got_ack), 32'(exp_ack));
        check_eq({tag, "_err"}, 32'(got_err), 32'(!exp_ack));
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (got_ack && !w) begin
            if (exp_q.size() == 0) check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
            else                   check_eq({tag, "_rd"}, rd, exp_q.pop_front());
        end
        if (exp_ack && w) begin
            for (int k = 0; k < 4; k++)
                if (s[k]) model[inst][a[11:2]][8*k +: 8] = d[8*k +: 8];
            if (inst) exp_ww2++; else exp_ww++;
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; cyc2 = 1'b0; stb2 = 1'b0; we = 1'b0;
    endtask

    task automatic burst(input logic [31:0] a0, input int n, input bit w, input logic [31:0] d0,
                         input int n_ok, input string tag);
        int       beat, cycles, n_ack, pushed;
        bit       got_err;
        logic [9:0] wi;
        beat = 0; cycles = 0; n_ack = 0; pushed = 0; got_err = 1'b0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; bte = BTE_LINEAR;
        for (int k = 0; k < n + 20; k++) begin
            adr   = a0 + 32'(4 * beat);
            dat_i = d0 + 32'(beat);
            cti   = (beat == n - 1) ? CTI_EOB : CTI_INCR;
            if (!w && beat < n_ok && beat == pushed) begin
                exp_q.push_back(model[0][a0[11:2] + 10'(beat)]);
                pushed++;
            end
            @(negedge clk);
            cycles++;
            if (err) begin got_err = 1'b1; break; end
            if (ack) begin
                wi = a0[11:2] + 10'(beat);
                if (w && beat < n_ok) begin
                    model[0][wi] = d0 + 32'(beat);
                    exp_ww++;
                end else if (!w) begin
                    if (exp_q.size() == 0) check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
                    else                   check_eq({tag, "_rd"}, dat_o, exp_q.pop_front());
                end
                n_ack++;
                beat++;
                if (beat == n) break;
            end
            @(posedge clk); #1;
        end
        check_eq({tag, "_acks"}, 32'(n_ack), 32'(n_ok));
        check_eq({tag, "_err"}, 32'(got_err), 32'(n_ok < n));
        check_eq({tag, "_cycles"}, 32'(cycles), 32'(n_ok + 32'(n_ok < n) + 1));
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic clear_count();
        @(posedge clk); #1; count_clear = 1'b1;
        @(posedge clk); #1; count_clear = 1'b0;
        exp_ww = 0; exp_ww2 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int  beat;
        bit  seen2;
        adr = '0; dat_i = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        cyc2 = 1'b0; stb2 = 1'b0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
        count_clear = 1'b0; threshold = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_dat", dat_o, 32'd0);
        check_eq("rst_ww", 32'(ww), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_rty", 32'(rty), 32'd0);
        rst = 1'b0;

        // Classic write/read and a single byte-lane update.
        classic(0, 32'h10, 32'hDEADBEEF, 4'hF, 1, CTI_CLASSIC, 2'b00, 1, 1, "cwr");
        classic(0, 32'h10, 32'h0, 4'hF, 0, CTI_CLASSIC, 2'b00, 1, 1, "crd");
        check_eq("ww_one", 32'(ww), 32'(exp_ww));
        classic(0, 32'h10, 32'h000000AA, 4'b0001, 1, CTI_CLASSIC, 2'b00, 1, 1, "bwr");
        classic(0, 32'h10, 32'h0, 4'hF, 0, CTI_CLASSIC, 2'b00, 1, 1, "brd");
        check_eq("byte_lane_model", model[0][4], 32'hDEADBEAA);

        // Eight-beat linear burst write then burst read-back.
        clear_count();
        burst(32'h100, 8, 1, 32'h1000_0000, 8, "bw8");
        check_eq("ww_burst", 32'(ww), 32'd8);
        burst(32'h100, 8, 0, 32'h0, 8, "br8");
        classic(0, 32'h104, 32'h0, 4'hF, 0, CTI_CLASSIC, 2'b00, 1, 1, "post_burst");

        // Error terminations leave the SRAM untouched.
        classic(0, 32'h0, 32'h0BADF00D, 4'hF, 1, CTI_CLASSIC, 2'b00, 1, 1, "w0");
        classic(0, 32'h20, 32'h12345678, 4'hF, 1, CTI_CLASSIC, 2'b00, 1, 1, "w20");
        classic(0, 32'h1000, 32'hFFFF_FFFF, 4'hF, 1, CTI_CLASSIC, 2'b00, 0, 1, "oor");
        classic(0, 32'h20, 32'hFFFF_FFFF, 4'hF, 1, CTI_INCR, 2'b01, 0, 1, "bte");
        classic(0, 32'h0, 32'h0, 4'hF, 0, CTI_CLASSIC, 2'b00, 1, 1, "r0");
        classic(0, 32'h20, 32'h0, 4'hF, 0, CTI_CLASSIC, 2'b00, 1, 1, "r20");
        check_eq("ww_after_err", 32'(ww), 32'(exp_ww));

        // Burst running off the top of memory.
        burst(32'hFF8, 4, 1, 32'hC0DE_0000, 2, "top");
        classic(0, 32'hFF8, 32'h0, 4'hF, 0, CTI_CLASSIC, 2'b00, 1, 1, "rtop0");
        classic(0, 32'hFFC, 32'h0, 4'hF, 0, CTI_CLASSIC, 2'b00, 1, 1, "rtop1");
        classic(0, 32'h0, 32'h0, 4'hF, 0, CTI_CLASSIC, 2'b00, 1, 1, "rwrap");
        check_eq("ww_top", 32'(ww), 32'(exp_ww));
        check_eq("irq_thr0", 32'(irq), 32'd0);

        // Wait-state instance: ack four cycles after the strobe.
        classic(1, 32'h40, 32'hA5A5_5A5A, 4'hF, 1, CTI_CLASSIC, 2'b00, 1, 4, "ws_wr");
        classic(1, 32'h40, 32'h0, 4'hF, 0, CTI_CLASSIC, 2'b00, 1, 4, "ws_rd");
        check_eq("ws_ww", 32'(ww2), 32'(exp_ww2));

        // Threshold interrupt and clear.
        clear_count();
        threshold = 16'd4;
        for (int i = 0; i < 3; i++)
            classic(0, 32'h300 + 32'(4 * i), 32'(i), 4'hF, 1, CTI_CLASSIC, 2'b00, 1, 1, "tw");
        @(posedge clk); #1;
        check_eq("irq_below", 32'(irq), 32'd0);
        classic(0, 32'h30C, 32'd3, 4'hF, 1, CTI_CLASSIC, 2'b00, 1, 1, "tw4");
        check_eq("ww_four", 32'(ww), 32'd4);
        check_eq("irq_latency", 32'(irq), 32'd0);
        @(posedge clk); #1;
        check_eq("irq_set", 32'(irq), 32'd1);
        clear_count();
        check_eq("ww_cleared", 32'(ww), 32'd0);
        check_eq("irq_hold", 32'(irq), 32'd1);
        @(posedge clk); #1;
        check_eq("irq_fall", 32'(irq), 32'd0);

        // Reset during the third beat of a burst write.
        classic(0, 32'h208, 32'h55AA55AA, 4'hF, 1, CTI_CLASSIC, 2'b00, 1, 1, "pre208");
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; bte = BTE_LINEAR; cti = CTI_INCR;
        beat = 0; seen2 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            adr = 32'h200 + 32'(4 * beat);
            dat_i = 32'hA0 + 32'(beat);
            @(negedge clk);
            if (ack) begin
                if (beat == 2) begin seen2 = 1'b1; break; end
                model[0][128 + beat] = 32'hA0 + 32'(beat);
                beat++;
            end
            @(posedge clk); #1;
        end
        check_eq("rst_beat2_seen", 32'(seen2), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_ack", 32'(ack), 32'd0);
        check_eq("rst_mid_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rst = 1'b0;
        exp_ww = 0;
        check_eq("rst_mid_ww", 32'(ww), 32'(exp_ww));
        classic(0, 32'h200, 32'h0, 4'hF, 0, CTI_CLASSIC, 2'b00, 1, 1, "r200");
        classic(0, 32'h204, 32'h0, 4'hF, 0, CTI_CLASSIC, 2'b00, 1, 1, "r204");
        classic(0, 32'h208, 32'h0, 4'hF, 0, CTI_CLASSIC, 2'b00, 1, 1, "r208");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
